// File: rtl/hit_ts_pkg.sv
// Shared constants for the hit timestamp capture block: register map, CTRL/STATUS
// bit positions and entry sizing.
package hit_ts_pkg;
   localparam int TS_W  = 32;
   localparam int AV_AW = 3;
   localparam int AV_DW = 16;

   localparam logic [AV_AW-1:0] ADDR_STATUS    = 3'd0;
   localparam logic [AV_AW-1:0] ADDR_CTRL      = 3'd1;
   localparam logic [AV_AW-1:0] ADDR_HEAD_TS_L = 3'd2;
   localparam logic [AV_AW-1:0] ADDR_HEAD_TS_H = 3'd3;
   localparam logic [AV_AW-1:0] ADDR_HEAD_MASK = 3'd4;
   localparam logic [AV_AW-1:0] ADDR_POP       = 3'd5;
   localparam logic [AV_AW-1:0] ADDR_NOW_L     = 3'd6;
   localparam logic [AV_AW-1:0] ADDR_NOW_H     = 3'd7;

   localparam int CTRL_IRQ_EN = 0;
   localparam int CTRL_CAP_EN = 1;
   localparam int CTRL_FLUSH  = 2;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVF   = 2;

   function automatic int entry_w(input int num_events);
      return TS_W + num_events;
   endfunction
endpackage

// File: rtl/hit_timestamp_capture_if.sv
// Avalon-MM slave bundle (word address, active-low write, registered read data).
// The CPU side drives through master; the capture block sits on slave.
interface hit_timestamp_capture_if;
   import hit_ts_pkg::*;

   logic [AV_AW-1:0] address;
   logic             chipselect;
   logic             write_n;
   logic [AV_DW-1:0] writedata;
   logic [AV_DW-1:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hit_ts_sync_fifo.sv
// Single-clock show-ahead FIFO; dout is the head entry combinationally, push lands next clk.
// Pop on empty is ignored; push on full is dropped unless a pop frees the slot that cycle; flush wins.
module hit_ts_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 36,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [LW-1:0]    level_o,
   output logic             empty_o,
   output logic             full_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push, do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LW'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   // a same-cycle pop makes room, so a push at full still lands
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         level_d = level_q + LW'(do_push) - LW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;
endmodule

// File: rtl/hit_timestamp_capture.sv
// Timestamps synchronized hit edges against a tick counter and queues them for the CPU.
// Reads return one clk after address; a full queue drops new hits and sets sticky overflow.
module hit_timestamp_capture
   import hit_ts_pkg::*;
#(
   parameter int NUM_EVENTS  = 4,
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   tick_i,
   input  logic [NUM_EVENTS-1:0]  event_i,
   hit_timestamp_capture_if.slave av,
   output logic                   irq
);
   localparam int EW = entry_w(NUM_EVENTS);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]                  tick_sync_q;
   logic                        tick_prev_q;
   logic [NUM_EVENTS-1:0]       ev_sync_q [SYNC_STAGES];
   logic [NUM_EVENTS-1:0]       ev_prev_q;
   logic                        tick_rise;
   logic [NUM_EVENTS-1:0]       hit_mask;

   logic [TS_W-1:0]             cnt_q, cnt_d;
   logic [15:0]                 shadow_q, shadow_d;
   logic                        ovf_q, ovf_d;
   logic                        irq_en_q, irq_en_d;
   logic                        cap_en_q, cap_en_d;
   logic                        irq_q, irq_d;
   logic [AV_DW-1:0]            rdata_q, rdata_d;

   logic                        wr_en, rd_en, ctrl_wr;
   logic                        push, pop, flush, ovf_set, ovf_clr;
   logic [EW-1:0]               fifo_dout;
   logic [LW-1:0]               fifo_level;
   logic                        fifo_empty, fifo_full;
   logic [TS_W-1:0]             head_ts;
   logic [NUM_EVENTS-1:0]       head_mask;
   logic                        unused_wdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_sync_q <= '0;
         tick_prev_q <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) ev_sync_q[i] <= '0;
         ev_prev_q   <= '0;
      end else begin
         tick_sync_q <= {tick_sync_q[0], tick_i};
         tick_prev_q <= tick_sync_q[1];
         ev_sync_q[0] <= event_i;
         for (int i = 1; i < SYNC_STAGES; i++) ev_sync_q[i] <= ev_sync_q[i-1];
         ev_prev_q   <= ev_sync_q[SYNC_STAGES-1];
      end
   end

   assign tick_rise = tick_sync_q[1] & ~tick_prev_q;
   assign hit_mask  = ev_sync_q[SYNC_STAGES-1] & ~ev_prev_q;

   assign wr_en   = av.chipselect & ~av.write_n;
   assign rd_en   = av.chipselect &  av.write_n;
   assign ctrl_wr = wr_en & (av.address == ADDR_CTRL);
   assign flush   = ctrl_wr & av.writedata[CTRL_FLUSH];
   assign pop     = wr_en & (av.address == ADDR_POP);
   assign ovf_clr = wr_en & (av.address == ADDR_STATUS);
   assign push    = cap_en_q & (|hit_mask);
   // a flush discards the colliding hit outright, so it is not an overflow
   assign ovf_set = push & fifo_full & ~pop & ~flush;
   assign unused_wdata = ^av.writedata[AV_DW-1:3];

   hit_ts_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .din_i   ({hit_mask, cnt_q}),
      .dout_o  (fifo_dout),
      .level_o (fifo_level),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign head_ts   = fifo_empty ? '0 : fifo_dout[TS_W-1:0];
   assign head_mask = fifo_empty ? '0 : fifo_dout[EW-1:TS_W];

   always_comb begin
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      ovf_d    = ovf_q;
      irq_en_d = irq_en_q;
      cap_en_d = cap_en_q;
      if (flush)          cnt_d = '0;
      else if (tick_rise) cnt_d = cnt_q + 32'd1;
      if (ovf_clr) ovf_d = 1'b0;
      if (ovf_set) ovf_d = 1'b1;
      if (ctrl_wr) begin
         irq_en_d = av.writedata[CTRL_IRQ_EN];
         cap_en_d = av.writedata[CTRL_CAP_EN];
      end
      // NOW_L freezes the upper half so the following NOW_H read matches it
      if (rd_en && av.address == ADDR_NOW_L) shadow_d = cnt_q[31:16];
      irq_d = irq_en_q & ~fifo_empty;
   end

   always_comb begin
      rdata_d = '0;
      case (av.address)
         ADDR_STATUS: begin
            rdata_d[15:8]     = 8'(fifo_level);
            rdata_d[ST_OVF]   = ovf_q;
            rdata_d[ST_FULL]  = fifo_full;
            rdata_d[ST_EMPTY] = fifo_empty;
         end
         ADDR_CTRL: begin
            rdata_d[CTRL_IRQ_EN] = irq_en_q;
            rdata_d[CTRL_CAP_EN] = cap_en_q;
         end
         ADDR_HEAD_TS_L: rdata_d = head_ts[15:0];
         ADDR_HEAD_TS_H: rdata_d = head_ts[31:16];
         ADDR_HEAD_MASK: rdata_d = 16'(head_mask);
         ADDR_NOW_L:     rdata_d = cnt_q[15:0];
         ADDR_NOW_H:     rdata_d = shadow_q;
         default:        rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         shadow_q <= '0;
         ovf_q    <= 1'b0;
         irq_en_q <= 1'b0;
         cap_en_q <= 1'b0;
         irq_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         ovf_q    <= ovf_d;
         irq_en_q <= irq_en_d;
         cap_en_q <= cap_en_d;
         irq_q    <= irq_d;
         rdata_q  <= rdata_d;
      end
   end

   assign av.readdata = rdata_q;
   assign irq         = irq_q;
endmodule
